mem_req_arbiter: RTL and testbench

- Collects memory requests from three decoder clients, plus internally generated refresh commands, into one request queue.
- Client 0 is the framestore writer, client 1 is the motion-compensation reader, client 2 is the display reader.
- The queue is presented through a FIFO-style read port that the memory controller drains with mem_req_rd_en / mem_req_rd_valid.
- Sits directly upstream of the memory controller and is the sole source of its mem_req_rd_* inputs.

---
 rtl/mem_req_arbiter_if.sv | 53 +++++
 rtl/mem_req_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_mem_req_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_req_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_req_arbiter_if : client request lanes and memory-request read port    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface mem_req_arbiter_if;
  logic [1:0]  c0_cmd;
  logic [21:0] c0_addr;
  logic [63:0] c0_dta;
  logic        c0_valid;
  logic        c0_ack;

  logic [1:0]  c1_cmd;
  logic [21:0] c1_addr;
  logic [63:0] c1_dta;
  logic        c1_valid;
  logic        c1_ack;

  logic [1:0]  c2_cmd;
  logic [21:0] c2_addr;
  logic [63:0] c2_dta;
  logic        c2_valid;
  logic        c2_ack;

  logic [1:0]  mem_req_rd_cmd;
  logic [21:0] mem_req_rd_addr;
  logic [63:0] mem_req_rd_dta;
  logic        mem_req_rd_en;
  logic        mem_req_rd_valid;
  logic        fifo_empty;

  // Clients and memory controller side
  modport master (
    output c0_cmd, c0_addr, c0_dta, c0_valid,
    output c1_cmd, c1_addr, c1_dta, c1_valid,
    output c2_cmd, c2_addr, c2_dta, c2_valid,
    output mem_req_rd_en,
    input  c0_ack, c1_ack, c2_ack,
    input  mem_req_rd_cmd, mem_req_rd_addr, mem_req_rd_dta,
    input  mem_req_rd_valid, fifo_empty
  );

  modport slave (
    input  c0_cmd, c0_addr, c0_dta, c0_valid,
    input  c1_cmd, c1_addr, c1_dta, c1_valid,
    input  c2_cmd, c2_addr, c2_dta, c2_valid,
    input  mem_req_rd_en,
    output c0_ack, c1_ack, c2_ack,
    output mem_req_rd_cmd, mem_req_rd_addr, mem_req_rd_dta,
    output mem_req_rd_valid, fifo_empty
  );
endinterface
`default_nettype wire

// File: rtl/mem_req_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_req_arbiter : 3-client round-robin + refresh into one request queue  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module mem_req_arbiter #(
  parameter int FIFO_ADDR_WIDTH = 4,
  parameter int REFRESH_PERIOD  = 1560
) (
  input wire logic         clk,
  input wire logic         rst,
  mem_req_arbiter_if.slave bus
);
  localparam int DEPTH   = 1 << FIFO_ADDR_WIDTH;
  localparam int CNT_W   = FIFO_ADDR_WIDTH + 1;
  localparam int REF_W   = $clog2(REFRESH_PERIOD);
  localparam int ENTRY_W = 2 + 22 + 64;

  localparam logic [CNT_W-1:0] FULL_CNT = {1'b1, {FIFO_ADDR_WIDTH{1'b0}}};
  localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_PERIOD - 1);

  localparam logic [1:0] CMD_NOOP    = 2'd0;
  localparam logic [1:0] CMD_REFRESH = 2'd1;

  logic [1:0]  cli_cmd   [3];
  logic [21:0] cli_addr  [3];
  logic [63:0] cli_dta   [3];
  logic [2:0]  cli_valid;
  logic [2:0]  ack;

  logic                       run_q;
  logic [FIFO_ADDR_WIDTH-1:0] wptr_q, wptr_d;
  logic [FIFO_ADDR_WIDTH-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0]           count_q, count_d;
  logic                       empty_q;
  logic [REF_W-1:0]           ref_cnt_q, ref_cnt_d;
  logic                       ref_pend_q, ref_pend_d;
  logic [1:0]                 rr_q, rr_d;

  logic [1:0]  rd_cmd_q;
  logic [21:0] rd_addr_q;
  logic [63:0] rd_dta_q;
  logic        rd_valid_q;

  logic [ENTRY_W-1:0] mem_q [DEPTH];

  logic               full;
  logic               can_wr;
  logic               ref_wrap;
  logic               ref_wr;
  logic               cli_gnt;
  logic               wr_en;
  logic               pop;
  logic [1:0]         cand1;
  logic [1:0]         cand2;
  logic [1:0]         sel_idx;
  logic               sel_found;
  logic [ENTRY_W-1:0] wr_data;
  logic [ENTRY_W-1:0] head;

  assign cli_cmd[0]  = bus.c0_cmd;
  assign cli_cmd[1]  = bus.c1_cmd;
  assign cli_cmd[2]  = bus.c2_cmd;
  assign cli_addr[0] = bus.c0_addr;
  assign cli_addr[1] = bus.c1_addr;
  assign cli_addr[2] = bus.c2_addr;
  assign cli_dta[0]  = bus.c0_dta;
  assign cli_dta[1]  = bus.c1_dta;
  assign cli_dta[2]  = bus.c2_dta;
  assign cli_valid   = {bus.c2_valid, bus.c1_valid, bus.c0_valid};

  // run_q keeps grants (and thus acks) off until the first edge after reset release
  assign full     = (count_q == FULL_CNT);
  assign can_wr   = run_q & ~full;
  assign ref_wrap = (ref_cnt_q == REF_LAST);
  assign pop      = bus.mem_req_rd_en & (count_q != '0);

  assign cand1 = (rr_q == 2'd2) ? 2'd0 : rr_q + 2'd1;
  assign cand2 = (rr_q == 2'd0) ? 2'd2 : rr_q - 2'd1;

  always_comb begin
    sel_found = 1'b1;
    sel_idx   = rr_q;
    if (cli_valid[rr_q]) begin
      sel_idx = rr_q;
    end else if (cli_valid[cand1]) begin
      sel_idx = cand1;
    end else if (cli_valid[cand2]) begin
      sel_idx = cand2;
    end else begin
      sel_found = 1'b0;
    end
  end

  assign ref_wr  = can_wr & ref_pend_q;
  assign cli_gnt = can_wr & ~ref_pend_q & sel_found;
  assign wr_en   = ref_wr | (cli_gnt & (cli_cmd[sel_idx] != CMD_NOOP));
  assign wr_data = ref_wr ? {CMD_REFRESH, 22'd0, 64'd0}
                          : {cli_cmd[sel_idx], cli_addr[sel_idx], cli_dta[sel_idx]};
  assign head    = mem_q[rptr_q];

  for (genvar g = 0; g < 3; g++) begin : g_ack
    assign ack[g] = cli_gnt & (sel_idx == 2'(g));
  end

  always_comb begin
    count_d = count_q;
    case ({wr_en, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    wptr_d     = wr_en ? wptr_q + FIFO_ADDR_WIDTH'(1) : wptr_q;
    rptr_d     = pop   ? rptr_q + FIFO_ADDR_WIDTH'(1) : rptr_q;
    ref_cnt_d  = ref_wrap ? '0 : ref_cnt_q + REF_W'(1);
    // A new wrap wins over the clear so a refresh is never dropped
    ref_pend_d = ref_wrap | (ref_pend_q & ~ref_wr);
    rr_d       = rr_q;
    if (cli_gnt) begin
      rr_d = (sel_idx == 2'd2) ? 2'd0 : sel_idx + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_q      <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      empty_q    <= 1'b1;
      ref_cnt_q  <= '0;
      ref_pend_q <= 1'b0;
      rr_q       <= 2'd0;
    end else begin
      run_q      <= 1'b1;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      empty_q    <= (count_d == '0);
      ref_cnt_q  <= ref_cnt_d;
      ref_pend_q <= ref_pend_d;
      rr_q       <= rr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wptr_q] <= wr_data;
    end
  end

  // Output data holds when idle; an rd_en on an empty queue zeroes it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_cmd_q   <= 2'd0;
      rd_addr_q  <= 22'd0;
      rd_dta_q   <= 64'd0;
      rd_valid_q <= 1'b0;
    end else if (bus.mem_req_rd_en) begin
      if (pop) begin
        rd_cmd_q   <= head[ENTRY_W-1 -: 2];
        rd_addr_q  <= head[85:64];
        rd_dta_q   <= head[63:0];
        rd_valid_q <= 1'b1;
      end else begin
        rd_cmd_q   <= 2'd0;
        rd_addr_q  <= 22'd0;
        rd_dta_q   <= 64'd0;
        rd_valid_q <= 1'b0;
      end
    end else begin
      rd_valid_q <= 1'b0;
    end
  end

  assign bus.c0_ack           = ack[0];
  assign bus.c1_ack           = ack[1];
  assign bus.c2_ack           = ack[2];
  assign bus.mem_req_rd_cmd   = rd_cmd_q;
  assign bus.mem_req_rd_addr  = rd_addr_q;
  assign bus.mem_req_rd_dta   = rd_dta_q;
  assign bus.mem_req_rd_valid = rd_valid_q;
  assign bus.fifo_empty       = empty_q;
endmodule
`default_nettype wire

// File: tb/tb_mem_req_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mem_req_arbiter : directed and table-driven checks of mem_req_arbiter  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_mem_req_arbiter;
  localparam logic [1:0] CMD_NOOP    = 2'd0;
  localparam logic [1:0] CMD_REFRESH = 2'd1;
  localparam logic [1:0] CMD_READ    = 2'd2;
  localparam logic [1:0] CMD_WRITE   = 2'd3;

  typedef struct packed {
    logic [2:0] valid;
    logic [2:0] exp_ack;
  } vec_t;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  int   n_chk = 0;
  int   n_err = 0;

  logic [1:0]  a_cmd [3];
  logic [21:0] a_addr[3];
  logic [63:0] a_dta [3];
  logic [2:0]  a_valid;
  logic        a_rd_en;
  logic [1:0]  b_cmd [3];
  logic [21:0] b_addr[3];
  logic [63:0] b_dta [3];
  logic [2:0]  b_valid;
  logic        b_rd_en;

  mem_req_arbiter_if ifa();
  mem_req_arbiter_if ifb();

  mem_req_arbiter #(.FIFO_ADDR_WIDTH(4), .REFRESH_PERIOD(1560)) dut_a (
    .clk(clk), .rst(rst_a), .bus(ifa));
  mem_req_arbiter #(.FIFO_ADDR_WIDTH(4), .REFRESH_PERIOD(8)) dut_b (
    .clk(clk), .rst(rst_b), .bus(ifb));

  always #5 clk = ~clk;

  assign ifa.c0_cmd = a_cmd[0];   assign ifa.c0_addr = a_addr[0];
  assign ifa.c0_dta = a_dta[0];   assign ifa.c0_valid = a_valid[0];
  assign ifa.c1_cmd = a_cmd[1];   assign ifa.c1_addr = a_addr[1];
  assign ifa.c1_dta = a_dta[1];   assign ifa.c1_valid = a_valid[1];
  assign ifa.c2_cmd = a_cmd[2];   assign ifa.c2_addr = a_addr[2];
  assign ifa.c2_dta = a_dta[2];   assign ifa.c2_valid = a_valid[2];
  assign ifa.mem_req_rd_en = a_rd_en;
  assign ifb.c0_cmd = b_cmd[0];   assign ifb.c0_addr = b_addr[0];
  assign ifb.c0_dta = b_dta[0];   assign ifb.c0_valid = b_valid[0];
  assign ifb.c1_cmd = b_cmd[1];   assign ifb.c1_addr = b_addr[1];
  assign ifb.c1_dta = b_dta[1];   assign ifb.c1_valid = b_valid[1];
  assign ifb.c2_cmd = b_cmd[2];   assign ifb.c2_addr = b_addr[2];
  assign ifb.c2_dta = b_dta[2];   assign ifb.c2_valid = b_valid[2];
  assign ifb.mem_req_rd_en = b_rd_en;

  wire [2:0]  a_ack = {ifa.c2_ack, ifa.c1_ack, ifa.c0_ack};
  wire [2:0]  b_ack = {ifb.c2_ack, ifb.c1_ack, ifb.c0_ack};
  wire [87:0] a_out = {ifa.mem_req_rd_cmd, ifa.mem_req_rd_addr, ifa.mem_req_rd_dta};
  wire [87:0] b_out = {ifb.mem_req_rd_cmd, ifb.mem_req_rd_addr, ifb.mem_req_rd_dta};

  logic [87:0] expq [$];
  vec_t        tbl [14];
  int          seq [3];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic chk(input string name, input logic [87:0] act, input logic [87:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_a();
    for (int n = 0; n < 3; n++) begin
      a_cmd[n] = CMD_NOOP; a_addr[n] = '0; a_dta[n] = '0;
    end
    a_valid = '0;
    a_rd_en = 1'b0;
  endtask

  task automatic clear_b();
    for (int n = 0; n < 3; n++) begin
      b_cmd[n] = CMD_NOOP; b_addr[n] = '0; b_dta[n] = '0;
    end
    b_valid = '0;
    b_rd_en = 1'b0;
  endtask

  // Leaves the bench in the cycle just before the first edge after release
  task automatic reset_a();
    clear_a();
    rst_a = 1'b0;
    cyc(); cyc();
    rst_a = 1'b1;
  endtask

  task automatic reset_b();
    clear_b();
    rst_b = 1'b0;
    cyc(); cyc();
    rst_b = 1'b1;
  endtask

  task automatic chk_out_a();
    if (ifa.mem_req_rd_valid) begin
      if (expq.size() == 0) chk("sb_unexpected_valid", 88'(ifa.mem_req_rd_valid), 88'd0);
      else                  chk("sb_entry", a_out, expq.pop_front());
    end
  endtask

  initial begin
    int acks, extra, k;
    logic exp_v;

    tbl[0]  = '{3'b111, 3'b001};
    tbl[1]  = '{3'b111, 3'b010};
    tbl[2]  = '{3'b111, 3'b100};
    tbl[3]  = '{3'b111, 3'b001};
    tbl[4]  = '{3'b111, 3'b010};
    tbl[5]  = '{3'b111, 3'b100};
    tbl[6]  = '{3'b110, 3'b010};
    tbl[7]  = '{3'b011, 3'b001};
    tbl[8]  = '{3'b101, 3'b100};
    tbl[9]  = '{3'b000, 3'b000};
    tbl[10] = '{3'b100, 3'b100};
    tbl[11] = '{3'b011, 3'b001};
    tbl[12] = '{3'b101, 3'b100};
    tbl[13] = '{3'b010, 3'b010};

    clear_a(); clear_b();
    rst_a = 1'b0; rst_b = 1'b0;
    a_valid = 3'b111; a_rd_en = 1'b1;
    cyc(); cyc(); settle();
    chk("rst_ack", 88'(a_ack), 88'd0);
    chk("rst_valid", 88'(ifa.mem_req_rd_valid), 88'd0);
    chk("rst_data", a_out, 88'd0);
    chk("rst_empty", 88'(ifa.fifo_empty), 88'd1);

    // Single read request, rd_en held
    reset_a();
    a_cmd[1] = CMD_READ; a_addr[1] = 22'h000100; a_valid[1] = 1'b1; a_rd_en = 1'b1;
    settle();
    chk("t1_no_ack_before_edge", 88'(a_ack), 88'd0);
    cyc(); settle();
    chk("t1_ack", 88'(a_ack), 88'(3'b010));
    cyc(); a_valid[1] = 1'b0; settle();
    chk("t1_valid_lat0", 88'(ifa.mem_req_rd_valid), 88'd0);
    cyc(); settle();
    chk("t1_valid", 88'(ifa.mem_req_rd_valid), 88'd1);
    chk("t1_entry", a_out, {CMD_READ, 22'h000100, 64'd0});
    cyc(); settle();
    chk("t1_valid_one_cycle", 88'(ifa.mem_req_rd_valid), 88'd0);

    // Round-robin table with scoreboard on the read port
    reset_a();
    a_rd_en = 1'b1;
    seq[0] = 0; seq[1] = 0; seq[2] = 0;
    cyc();
    for (int i = 0; i < 14; i++) begin
      for (int n = 0; n < 3; n++) begin
        a_valid[n] = tbl[i].valid[n];
        a_cmd[n]   = CMD_READ;
        a_addr[n]  = 22'(((n + 1) << 8) | seq[n]);
        a_dta[n]   = 64'd0;
      end
      settle();
      chk_out_a();
      chk($sformatf("rr_ack[%0d]", i), 88'(a_ack), 88'(tbl[i].exp_ack));
      for (int n = 0; n < 3; n++) begin
        if (tbl[i].exp_ack[n]) begin
          expq.push_back({CMD_READ, a_addr[n], 64'd0});
          seq[n]++;
        end
      end
      cyc();
    end
    a_valid = '0;
    for (int i = 0; i < 4; i++) begin
      settle(); chk_out_a(); cyc();
    end
    chk("sb_drained", 88'(expq.size()), 88'd0);

    // NOOP is acked, not queued, and still advances the pointer
    a_cmd[0] = CMD_NOOP; a_valid[0] = 1'b1;
    settle();
    chk("noop_ack", 88'(a_ack), 88'(3'b001));
    cyc();
    a_cmd[0] = CMD_READ; a_addr[0] = 22'h3F0; a_addr[1] = 22'h3F1; a_valid = 3'b011;
    settle();
    chk("noop_rr_adv", 88'(a_ack), 88'(3'b010));
    if (a_ack[1]) expq.push_back({CMD_READ, 22'h3F1, 64'd0});
    cyc(); a_valid = '0;
    for (int i = 0; i < 3; i++) begin
      settle(); chk_out_a(); cyc();
    end
    chk("noop_sb_drained", 88'(expq.size()), 88'd0);
    settle();
    chk("noop_empty", 88'(ifa.fifo_empty), 88'd1);

    // Fill to full with writes, then one pop admits exactly one more
    reset_a();
    a_cmd[0] = CMD_WRITE; a_dta[0] = 64'h0123456789abcdef; a_addr[0] = 22'h400; a_valid[0] = 1'b1;
    acks = 0;
    for (int i = 0; i < 22; i++) begin
      cyc(); a_addr[0] = 22'h400 + 22'(acks); settle();
      if (a_ack[0]) acks++;
    end
    chk("full_acks", 88'(acks), 88'd16);
    chk("full_not_empty", 88'(ifa.fifo_empty), 88'd0);
    chk("full_no_ack", 88'(a_ack), 88'd0);
    a_rd_en = 1'b1;
    cyc(); a_rd_en = 1'b0; a_addr[0] = 22'h400 + 22'(acks); settle();
    chk("full_pop_valid", 88'(ifa.mem_req_rd_valid), 88'd1);
    chk("full_pop_entry", a_out, {CMD_WRITE, 22'h400, 64'h0123456789abcdef});
    chk("full_freed_ack", 88'(a_ack), 88'(3'b001));
    if (a_ack[0]) acks++;
    extra = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(); a_addr[0] = 22'h400 + 22'(acks); settle();
      if (a_ack[0]) extra++;
    end
    chk("full_no_extra_ack", 88'(extra), 88'd0);

    // Asynchronous reset with entries queued
    reset_a();
    a_cmd[1] = CMD_READ; a_addr[1] = 22'h500; a_valid[1] = 1'b1;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(); a_addr[1] = 22'h500 + 22'(acks); settle();
      if (a_ack[1]) acks++;
    end
    chk("ar_acks", 88'(acks), 88'd6);
    cyc(); a_valid[1] = 1'b0; a_rd_en = 1'b1;
    cyc(); a_rd_en = 1'b0; settle();
    chk("ar_pre_valid", 88'(ifa.mem_req_rd_valid), 88'd1);
    rst_a = 1'b0; a_cmd[0] = CMD_READ; a_valid[0] = 1'b1;
    #1;
    chk("ar_valid", 88'(ifa.mem_req_rd_valid), 88'd0);
    chk("ar_data", a_out, 88'd0);
    chk("ar_empty", 88'(ifa.fifo_empty), 88'd1);
    chk("ar_ack", 88'(a_ack), 88'd0);
    cyc(); cyc();
    rst_a = 1'b1; a_valid = '0; a_rd_en = 1'b1;
    cyc(); cyc(); settle();
    chk("ar_post_valid", 88'(ifa.mem_req_rd_valid), 88'd0);
    chk("ar_post_empty", 88'(ifa.fifo_empty), 88'd1);

    // Refresh every 8 cycles with idle clients
    reset_b();
    b_rd_en = 1'b1;
    for (int n = 1; n <= 34; n++) begin
      cyc(); settle();
      exp_v = (n >= 10) && (((n - 10) % 8) == 0);
      chk($sformatf("ref_valid[%0d]", n), 88'(ifb.mem_req_rd_valid), 88'(exp_v));
      if (exp_v) chk($sformatf("ref_entry[%0d]", n), b_out, {CMD_REFRESH, 22'd0, 64'd0});
    end

    // Refresh pending while full: queued ahead of c2, only once
    reset_b();
    b_cmd[2] = CMD_WRITE; b_dta[2] = 64'hfeedface_cafef00d; b_addr[2] = 22'h200; b_valid[2] = 1'b1;
    k = 0;
    for (int n = 1; n <= 24; n++) begin
      cyc(); b_addr[2] = 22'h200 + 22'(k); settle();
      if (b_ack[2]) k++;
    end
    chk("rf_fill_acks", 88'(k), 88'd14);
    for (int n = 25; n <= 42; n++) begin
      cyc(); settle();
      chk($sformatf("rf_full_no_ack[%0d]", n), 88'(b_ack), 88'd0);
    end
    cyc(); b_rd_en = 1'b1; settle();
    chk("rf_e43_no_ack", 88'(b_ack), 88'd0);
    cyc(); settle();
    chk("rf_refresh_first", 88'(b_ack), 88'd0);
    chk("rf_pop1", b_out, {CMD_WRITE, 22'h200, 64'hfeedface_cafef00d});
    cyc(); b_rd_en = 1'b0; settle();
    chk("rf_c2_ack_next", 88'(b_ack), 88'(3'b100));
    chk("rf_pop2", b_out, {CMD_WRITE, 22'h201, 64'hfeedface_cafef00d});
    cyc(); b_valid[2] = 1'b0; b_rd_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      cyc(); settle();
      chk($sformatf("rf_drain_valid[%0d]", i), 88'(ifb.mem_req_rd_valid), 88'd1);
      if (i == 14) chk("rf_drain_refresh", b_out, {CMD_REFRESH, 22'd0, 64'd0});
      if (i == 15) chk("rf_drain_c2", b_out, {CMD_WRITE, 22'h20E, 64'hfeedface_cafef00d});
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
`default_nettype wire
